// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC configuration sequencer: state encoding,
// register count, default machine timing tables and a table slice helper.
package crtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        DATA,
        RESTORE,
        ACC,
        ACK
    } crtc_state_t;

    localparam int CRTC_NREGS = 16;

    // R0 in the low byte; standard 50 Hz mode and an overscan variant.
    localparam logic [127:0] CRTC_TBL_STD  = 128'h00C00030_00000700_1E190026_8E2E283F;
    localparam logic [127:0] CRTC_TBL_OVSC = 128'h00C00030_00000700_22220026_8E2E303F;

    function automatic logic [7:0] tbl_byte(input logic [127:0] tbl, input logic [3:0] idx);
        return tbl[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/crtc_cfg_seq.sv
// CRTC register-port master: replays a 16-register timing table after reset
// or on reload, and passes CPU accesses through between sequences.
module crtc_cfg_seq
    import crtc_pkg::*;
#(
    parameter logic [127:0] TBL_A = 128'h0,
    parameter logic [127:0] TBL_B = 128'h0
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       reload,
    input  logic       tbl_sel,
    input  logic       cpu_req,
    input  logic       cpu_rs,
    input  logic       cpu_rnw,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       cpu_ack,
    output logic       busy,
    output logic       done,
    output logic       crtc_en,
    output logic       crtc_ncs,
    output logic       crtc_rnw,
    output logic       crtc_rs,
    output logic [7:0] crtc_di,
    input  logic [7:0] crtc_do
);

    // state   | meaning
    // IDLE    | bus idle; start sequence if pending, else serve cpu_req
    // SEL     | write address register with idx
    // DATA    | write table byte idx
    // RESTORE | write address register back to the CPU's shadow value
    // ACC     | one CPU bus cycle
    // ACK     | cpu_ack pulse, bus idle

    localparam logic [3:0] LAST_IDX = 4'(CRTC_NREGS - 1);

    crtc_state_t state, state_nxt;
    logic        pending;
    logic [3:0]  idx;
    logic        tsel;
    logic [4:0]  shadow;
    logic        seq_start;

    assign seq_start = (state == IDLE) && (pending || reload);

    always_comb begin
        state_nxt = state;
        crtc_en   = 1'b0;
        crtc_ncs  = 1'b1;
        crtc_rnw  = 1'b1;
        crtc_rs   = 1'b0;
        crtc_di   = 8'h00;
        case (state)
            IDLE: begin
                if (pending || reload)
                    state_nxt = SEL;
                else if (cpu_req)
                    state_nxt = ACC;
            end
            SEL: begin
                crtc_en   = 1'b1;
                crtc_ncs  = 1'b0;
                crtc_rnw  = 1'b0;
                crtc_di   = {4'h0, idx};
                state_nxt = DATA;
            end
            DATA: begin
                crtc_en   = 1'b1;
                crtc_ncs  = 1'b0;
                crtc_rnw  = 1'b0;
                crtc_rs   = 1'b1;
                crtc_di   = tbl_byte(tsel ? TBL_B : TBL_A, idx);
                state_nxt = (idx == LAST_IDX) ? RESTORE : SEL;
            end
            RESTORE: begin
                crtc_en   = 1'b1;
                crtc_ncs  = 1'b0;
                crtc_rnw  = 1'b0;
                crtc_di   = {3'b000, shadow};
                state_nxt = IDLE;
            end
            ACC: begin
                crtc_en   = 1'b1;
                crtc_ncs  = 1'b0;
                crtc_rnw  = cpu_rnw;
                crtc_rs   = cpu_rs;
                crtc_di   = cpu_di;
                state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            state   <= IDLE;
            pending <= 1'b1;
            idx     <= 4'h0;
            tsel    <= 1'b0;
            shadow  <= 5'h00;
            done    <= 1'b0;
            cpu_do  <= 8'hFF;
        end else begin
            state <= state_nxt;
            // A reload coinciding with the start is served by that same sequence.
            if (seq_start) begin
                pending <= 1'b0;
                tsel    <= tbl_sel;
                idx     <= 4'h0;
                done    <= 1'b0;
            end else if (reload) begin
                pending <= 1'b1;
            end
            if (state == DATA)
                idx <= idx + 4'd1;
            if (state == RESTORE)
                done <= 1'b1;
            if (state == ACC) begin
                cpu_do <= crtc_do;
                if (!cpu_rnw && !cpu_rs)
                    shadow <= cpu_di[4:0];
            end
        end
    end

    assign cpu_ack = (state == ACK);
    assign busy    = pending || (state == SEL) || (state == DATA) || (state == RESTORE);

endmodule

// File: tb/tb_crtc_cfg_seq.sv
// Scoreboard bench for crtc_cfg_seq: expected CRTC bus cycles and CPU acks are
// queued with their cycle numbers; a monitor pops and compares them.
module tb_crtc_cfg_seq;

    localparam logic [127:0] TA = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] TB = 128'h00C00030_00000700_1E190026_8E2E283F;

    logic       CLOCK = 1'b0;
    logic       nRESET;
    logic       reload, tbl_sel, cpu_req, cpu_rs, cpu_rnw;
    logic [7:0] cpu_di, cpu_do, crtc_di, crtc_do;
    logic       cpu_ack, busy, done, crtc_en, crtc_ncs, crtc_rnw, crtc_rs;

    crtc_cfg_seq #(.TBL_A(TA), .TBL_B(TB)) dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .reload(reload), .tbl_sel(tbl_sel),
        .cpu_req(cpu_req), .cpu_rs(cpu_rs), .cpu_rnw(cpu_rnw), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_ack(cpu_ack), .busy(busy), .done(done),
        .crtc_en(crtc_en), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw),
        .crtc_rs(crtc_rs), .crtc_di(crtc_di), .crtc_do(crtc_do)
    );

    always #5 CLOCK = ~CLOCK;

    int tick = 0;
    always @(posedge CLOCK) tick <= tick + 1;

    typedef struct {
        int         cyc;
        logic       rnw;
        logic       rs;
        logic [7:0] di;
    } bus_t;

    typedef struct {
        int         cyc;
        bit         chk_do;
        logic [7:0] dat;
    } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] bytes_a[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    logic [7:0] bytes_b[16] = '{8'h3F, 8'h28, 8'h2E, 8'h8E, 8'h26, 8'h00, 8'h19, 8'h1E,
                                8'h00, 8'h07, 8'h00, 8'h00, 8'h30, 8'h00, 8'hC0, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, act, exp, tick);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic goto(input int abs_cyc);
        while (tick < abs_cyc) step();
    endtask

    task automatic push_bus(input int cyc, input logic rnw, input logic rs, input logic [7:0] di);
        bus_t e;
        e.cyc = cyc; e.rnw = rnw; e.rs = rs; e.di = di;
        bus_q.push_back(e);
    endtask

    task automatic push_ack(input int cyc, input bit chk_do, input logic [7:0] dat);
        ack_t e;
        e.cyc = cyc; e.chk_do = chk_do; e.dat = dat;
        ack_q.push_back(e);
    endtask

    // Sequence whose decision cycle (IDLE) is absolute cycle b.
    task automatic push_seq(input int b, input logic [7:0] bytes[16], input int npairs,
                            input bit with_restore, input logic [7:0] rest);
        for (int n = 0; n < npairs; n++) begin
            push_bus(b + 2*n + 1, 1'b0, 1'b0, 8'(n));
            push_bus(b + 2*n + 2, 1'b0, 1'b1, bytes[n]);
        end
        if (with_restore)
            push_bus(b + 33, 1'b0, 1'b0, rest);
    endtask

    task automatic monitor();
        bus_t eb;
        ack_t ea;
        forever begin
            @(negedge CLOCK);
            if (crtc_en || !crtc_ncs) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got rnw=%0b rs=%0b di=0x%0h at tick %0d, required no bus cycle",
                             crtc_rnw, crtc_rs, crtc_di, tick);
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_cycle", tick, eb.cyc);
                    chk("bus_pins", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di},
                        {1'b1, 1'b0, eb.rnw, eb.rs, eb.di});
                end
            end
            if (cpu_ack) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got cpu_ack=1 at tick %0d, required 0", tick);
                end else begin
                    ea = ack_q.pop_front();
                    chk("ack_cycle", tick, ea.cyc);
                    if (ea.chk_do) chk("cpu_do", cpu_do, ea.dat);
                end
            end
        end
    endtask

    int b0, b2, b3, b4, b5, b6;

    initial begin
        nRESET = 1'b0; reload = 1'b0; tbl_sel = 1'b0; cpu_req = 1'b0;
        cpu_rs = 1'b0; cpu_rnw = 1'b1; cpu_di = 8'h00; crtc_do = 8'h00;
        fork monitor(); join_none

        repeat (3) step();
        chk("rst_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {4'b0110, 8'h00});
        chk("rst_cpu_do", cpu_do, 8'hFF);
        chk("rst_ack_done_busy", {cpu_ack, done, busy}, 3'b001);

        // Power-up sequence with table A.
        nRESET = 1'b1;
        b0 = tick;
        push_seq(b0, bytes_a, 16, 1'b1, 8'h00);
        goto(b0 + 32);
        chk("seq_busy_mid", {busy, done}, 2'b10);
        goto(b0 + 34);
        chk("seq_end", {busy, done}, 2'b01);

        // CPU selects R14, then reads data.
        cpu_req = 1'b1; cpu_rs = 1'b0; cpu_rnw = 1'b0; cpu_di = 8'h0E;
        push_bus(b0 + 35, 1'b0, 1'b0, 8'h0E);
        push_ack(b0 + 36, 1'b0, 8'h00);
        goto(b0 + 36);
        cpu_req = 1'b0;
        goto(b0 + 37);
        cpu_req = 1'b1; cpu_rs = 1'b1; cpu_rnw = 1'b1; cpu_di = 8'h00; crtc_do = 8'h3C;
        push_bus(b0 + 38, 1'b1, 1'b1, 8'h00);
        push_ack(b0 + 39, 1'b1, 8'h3C);
        goto(b0 + 39);
        cpu_req = 1'b0;

        // CPU selects R12.
        goto(b0 + 40);
        cpu_req = 1'b1; cpu_rs = 1'b0; cpu_rnw = 1'b0; cpu_di = 8'h0C;
        push_bus(b0 + 41, 1'b0, 1'b0, 8'h0C);
        push_ack(b0 + 42, 1'b0, 8'h00);
        goto(b0 + 42);
        cpu_req = 1'b0;

        // Reload with table B; tbl_sel changes mid-sequence; CPU request at cycle 5 waits.
        goto(b0 + 43);
        b2 = tick;
        reload = 1'b1; tbl_sel = 1'b1;
        push_seq(b2, bytes_b, 16, 1'b1, 8'h0C);
        push_bus(b2 + 35, 1'b0, 1'b1, 8'h55);
        push_ack(b2 + 36, 1'b0, 8'h00);
        step();
        reload = 1'b0;
        chk("reload_start", {busy, done}, 2'b10);
        goto(b2 + 3);
        tbl_sel = 1'b0;
        goto(b2 + 5);
        cpu_req = 1'b1; cpu_rs = 1'b1; cpu_rnw = 1'b0; cpu_di = 8'h55;
        goto(b2 + 34);
        chk("seq_b_end", {busy, done}, 2'b01);
        goto(b2 + 36);
        cpu_req = 1'b0;

        // Reload during a sequence queues a second, back-to-back sequence.
        goto(b2 + 37);
        b3 = tick;
        reload = 1'b1;
        push_seq(b3, bytes_a, 16, 1'b1, 8'h0C);
        b4 = b3 + 34;
        push_seq(b4, bytes_b, 16, 1'b1, 8'h0C);
        step();
        reload = 1'b0;
        goto(b3 + 10);
        reload = 1'b1; tbl_sel = 1'b1;
        step();
        reload = 1'b0;
        goto(b3 + 34);
        chk("requeued_gap", {busy, done}, 2'b11);
        goto(b4 + 34);
        chk("requeued_end", {busy, done}, 2'b01);

        // Reset at cycle 20 aborts; sequence restarts at R0 with shadow cleared.
        b5 = tick;
        reload = 1'b1; tbl_sel = 1'b0;
        push_seq(b5, bytes_a, 10, 1'b0, 8'h00);
        step();
        reload = 1'b0;
        goto(b5 + 20);
        nRESET = 1'b0;
        step();
        chk("abort_bus", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {4'b0110, 8'h00});
        chk("abort_flags", {cpu_ack, done, busy}, 3'b001);
        chk("abort_cpu_do", cpu_do, 8'hFF);
        step();
        nRESET = 1'b1;
        b6 = tick;
        push_seq(b6, bytes_a, 16, 1'b1, 8'h00);
        goto(b6 + 34);
        chk("restart_end", {busy, done}, 2'b01);

        repeat (3) step();
        chk("bus_q_drained", bus_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
